// File: rtl/uart_sample_framer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sample_framer
//  Description : Buffers 16-bit samples in a FIFO and, once a frame's worth is
//                held, emits SYNC, seq, samples (MSB byte first) and an XOR
//                checksum to a UART transmitter, one byte per handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_sample_framer #(
  parameter int unsigned FRAME_LEN  = 4,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                        osc_clk,
  input  logic                        i_Rst_n,
  input  logic                        i_Sample_DV,
  input  logic [15:0]                 i_Sample,
  output logic                        o_Tx_DV,
  output logic [7:0]                  o_Tx_Byte,
  input  logic                        i_Tx_Active,
  input  logic                        i_Tx_Done,
  output logic                        o_Busy,
  output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count,
  output logic                        o_Overflow
);

  localparam int unsigned c_PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned c_CNT_W    = $clog2(FIFO_DEPTH) + 1;
  // Byte indices: 0 = sync, 1 = seq, 2..2*FRAME_LEN+1 = samples, last = chk.
  localparam int unsigned c_LAST     = 2 * FRAME_LEN + 2;
  localparam int unsigned c_IDX_W    = $clog2(c_LAST + 1);

  localparam logic [c_CNT_W-1:0] c_DEPTH     = c_CNT_W'(FIFO_DEPTH);
  localparam logic [c_CNT_W-1:0] c_FRAME     = c_CNT_W'(FRAME_LEN);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_LAST  = c_PTR_W'(FIFO_DEPTH - 1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(c_LAST);
  localparam logic [c_IDX_W-1:0] c_IDX_FIRST_LSB = c_IDX_W'(3);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST_LSB  = c_IDX_W'(c_LAST - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_ONE   = c_IDX_W'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  state_t               state_q;
  logic [c_IDX_W-1:0]   idx_q;
  logic [7:0]           seq_q;
  logic [7:0]           chk_q;
  logic                 tx_dv_q;
  logic [7:0]           tx_byte_q;

  logic [15:0]          mem_q [FIFO_DEPTH];
  logic [c_PTR_W-1:0]   wr_ptr_q;
  logic [c_PTR_W-1:0]   rd_ptr_q;
  logic [c_CNT_W-1:0]   count_q;
  logic                 overflow_q;

  logic                 w_push;
  logic                 w_drop;
  logic                 w_pop;
  logic                 w_is_lsb;
  logic [c_PTR_W-1:0]   w_wr_nxt;
  logic [c_PTR_W-1:0]   w_rd_nxt;
  logic [15:0]          w_head;
  logic [c_IDX_W-1:0]   w_load_idx;
  logic [7:0]           w_load_byte;

  // Fullness uses the pre-edge count, so a same-cycle pop never makes room.
  assign w_push   = i_Sample_DV && (count_q < c_DEPTH);
  assign w_drop   = i_Sample_DV && (count_q == c_DEPTH);
  assign w_is_lsb = (idx_q >= c_IDX_FIRST_LSB) && (idx_q <= c_IDX_LAST_LSB) && idx_q[0];
  assign w_pop    = (state_q == S_WAIT_IDLE) && !i_Tx_Done && w_is_lsb;

  assign w_wr_nxt = (wr_ptr_q == c_PTR_LAST) ? '0 : wr_ptr_q + c_PTR_ONE;
  assign w_rd_nxt = (rd_ptr_q == c_PTR_LAST) ? '0 : rd_ptr_q + c_PTR_ONE;

  // The byte loaded on a pop cycle belongs to the sample behind the one leaving.
  assign w_head     = w_pop ? mem_q[w_rd_nxt] : mem_q[rd_ptr_q];
  assign w_load_idx = (state_q == S_IDLE) ? '0 : idx_q + c_IDX_ONE;

  // Select the byte that will be presented at the next S_LOAD entry.
  always_comb begin
    w_load_byte = SYNC_BYTE;
    if (w_load_idx == '0) begin
      w_load_byte = SYNC_BYTE;
    end else if (w_load_idx == c_IDX_ONE) begin
      w_load_byte = seq_q;
    end else if (w_load_idx == c_IDX_LAST) begin
      w_load_byte = chk_q;
    end else if (!w_load_idx[0]) begin
      w_load_byte = w_head[15:8];
    end else begin
      w_load_byte = w_head[7:0];
    end
  end

  // Sample storage; contents need no reset because pointers/count gate them.
  always_ff @(posedge osc_clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= i_Sample;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge osc_clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (w_push) begin
        wr_ptr_q <= w_wr_nxt;
      end
      if (w_pop) begin
        rd_ptr_q <= w_rd_nxt;
      end
      if (w_push && !w_pop) begin
        count_q <= count_q + c_CNT_ONE;
      end else if (!w_push && w_pop) begin
        count_q <= count_q - c_CNT_ONE;
      end
      if (w_drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Frame sequencer with per-byte transmitter handshake and registered outputs.
  always_ff @(posedge osc_clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      seq_q     <= 8'h00;
      chk_q     <= 8'h00;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
    end else begin
      tx_dv_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (count_q >= c_FRAME) begin
            state_q   <= S_LOAD;
            idx_q     <= '0;
            chk_q     <= 8'h00;
            tx_dv_q   <= 1'b1;
            tx_byte_q <= w_load_byte;
          end
        end
        S_LOAD: begin
          // Sync and the checksum itself stay out of the XOR.
          if ((idx_q != '0) && (idx_q != c_IDX_LAST)) begin
            chk_q <= chk_q ^ tx_byte_q;
          end
          state_q <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (i_Tx_Active) begin
            state_q <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (i_Tx_Done) begin
            state_q <= S_WAIT_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          if (!i_Tx_Done) begin
            if (idx_q == c_IDX_LAST) begin
              state_q <= S_IDLE;
              seq_q   <= seq_q + 8'd1;
            end else begin
              state_q   <= S_LOAD;
              idx_q     <= w_load_idx;
              tx_dv_q   <= 1'b1;
              tx_byte_q <= w_load_byte;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_Tx_DV      = tx_dv_q;
  assign o_Tx_Byte    = tx_byte_q;
  assign o_Busy       = (state_q != S_IDLE);
  assign o_Fifo_Count = count_q;
  assign o_Overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_sample_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_sample_framer
//  Description : Directed, table-driven bench for uart_sample_framer with a
//                simple UART transmitter handshake model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_sample_framer;

  localparam int FRAME_LEN  = 4;
  localparam int FIFO_DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_dv;
  logic [15:0] sample;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        tx_active;
  logic        tx_done;
  logic        busy;
  logic [4:0]  fifo_count;
  logic        overflow;

  always #5 clk = ~clk;

  uart_sample_framer #(
    .FRAME_LEN  (FRAME_LEN),
    .FIFO_DEPTH (FIFO_DEPTH),
    .SYNC_BYTE  (8'hA5)
  ) u_dut (
    .osc_clk      (clk),
    .i_Rst_n      (rst_n),
    .i_Sample_DV  (sample_dv),
    .i_Sample     (sample),
    .o_Tx_DV      (tx_dv),
    .o_Tx_Byte    (tx_byte),
    .i_Tx_Active  (tx_active),
    .i_Tx_Done    (tx_done),
    .o_Busy       (busy),
    .o_Fifo_Count (fifo_count),
    .o_Overflow   (overflow)
  );

  int          cmp_cnt = 0;
  int          err_cnt = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: 10 bits per byte, tx_clks clocks of activity per byte.
  int tx_clks = 40;
  bit tx_hold = 1'b0;
  initial begin
    tx_active = 1'b0;
    tx_done   = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_dv && rst_n) begin
        while (tx_hold) @(negedge clk);
        tx_active = 1'b1;
        repeat (tx_clks) @(negedge clk);
        tx_active = 1'b0;
        tx_done   = 1'b1;
        @(negedge clk);
        tx_done   = 1'b0;
      end
    end
  end

  // Byte monitor.
  logic [7:0]  got[$];
  int unsigned got_cyc[$];
  int          dv_consec = 0;
  logic        prev_dv = 1'b0;
  always @(negedge clk) begin
    if (tx_dv) begin
      got.push_back(tx_byte);
      got_cyc.push_back(cyc);
    end
    if (tx_dv && prev_dv) dv_consec++;
    prev_dv = tx_dv;
  end

  logic [15:0] smp_log [0:2047];

  typedef struct {
    logic [15:0] smp;
    logic [7:0]  hi;
    logic [7:0]  lo;
  } vec_t;
  vec_t vt [4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gb(input int i);
    if (i < got.size()) return got[i];
    return 8'hxx;
  endfunction

  function automatic int gc(input int i);
    if (i < got_cyc.size()) return int'(got_cyc[i]);
    return -1;
  endfunction

  task automatic push_range(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample_dv = 1'b1;
      sample    = smp_log[first + i];
    end
    @(negedge clk);
    sample_dv = 1'b0;
  endtask

  task automatic wait_bytes(input string nm, input int n, input int budget);
    int k = 0;
    while (got.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({nm, "_bytes_arrived"}, 32'(got.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({nm, "_idle_reached"}, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_tx_dv"},   32'(tx_dv),      32'd0);
    check({nm, "_tx_byte"}, 32'(tx_byte),    32'd0);
    check({nm, "_busy"},    32'(busy),       32'd0);
    check({nm, "_count"},   32'(fifo_count), 32'd0);
    check({nm, "_ovf"},     32'(overflow),   32'd0);
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst_n     = 1'b0;
    sample_dv = 1'b0;
    @(negedge clk);
    check_reset_vals(nm);
    rst_n = 1'b1;
    got.delete();
    got_cyc.delete();
  endtask

  // Expected frame built from the logged samples.
  task automatic check_frame(input string nm, input int off, input logic [7:0] seq, input int sbase);
    logic [7:0] c;
    logic [15:0] s;
    c = seq;
    check({nm, "_sync"}, 32'(gb(off)), 32'h A5);
    check({nm, "_seq"},  32'(gb(off + 1)), 32'(seq));
    for (int i = 0; i < FRAME_LEN; i++) begin
      s = smp_log[sbase + i];
      check($sformatf("%s_s%0d_hi", nm, i), 32'(gb(off + 2 + 2*i)), 32'(s[15:8]));
      check($sformatf("%s_s%0d_lo", nm, i), 32'(gb(off + 3 + 2*i)), 32'(s[7:0]));
      c = c ^ s[15:8] ^ s[7:0];
    end
    check({nm, "_chk"}, 32'(gb(off + 2*FRAME_LEN + 2)), 32'(c));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    sample_dv = 1'b0;
    sample    = 16'h0000;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst_n = 1'b1;

    // ---------------- basic frame + start latency ----------------
    vt[0] = '{16'h1234, 8'h12, 8'h34};
    vt[1] = '{16'hABCD, 8'hAB, 8'hCD};
    vt[2] = '{16'h0001, 8'h00, 8'h01};
    vt[3] = '{16'h8000, 8'h80, 8'h00};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sample_dv = 1'b1;
      sample    = vt[i].smp;
    end
    @(negedge clk);
    sample_dv = 1'b0;
    repeat (10) @(negedge clk);
    check("three_no_dv", 32'(got.size()), 32'd0);
    check("three_count", 32'(fifo_count), 32'd3);
    sample_dv = 1'b1;
    sample    = vt[3].smp;
    @(negedge clk);
    sample_dv = 1'b0;
    check("lat_edgeN_dv",    32'(tx_dv),      32'd0);
    check("lat_edgeN_count", 32'(fifo_count), 32'd4);
    @(negedge clk);
    check("lat_edgeN1_dv",   32'(tx_dv),   32'd1);
    check("lat_edgeN1_byte", 32'(tx_byte), 32'hA5);
    check("lat_edgeN1_busy", 32'(busy),    32'd1);
    wait_bytes("basic", 11, 1500);
    check("basic_sync", 32'(gb(0)), 32'hA5);
    check("basic_seq",  32'(gb(1)), 32'h00);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("basic_v%0d_hi", i), 32'(gb(2 + 2*i)), 32'(vt[i].hi));
      check($sformatf("basic_v%0d_lo", i), 32'(gb(3 + 2*i)), 32'(vt[i].lo));
    end
    check("basic_chk", 32'(gb(10)), 32'hC1);
    check("basic_gap", 32'(gc(1) - gc(0)), 32'd42);
    wait_idle("basic", 200);
    check("basic_end_count", 32'(fifo_count), 32'd0);
    check("basic_end_busy",  32'(busy),       32'd0);

    // ---------------- back-to-back frames ----------------
    do_reset("rst_b2b");
    for (int i = 0; i < 8; i++) smp_log[i] = 16'(16'h1111 * (i + 1) ^ 16'h0F0F);
    push_range(0, 8);
    wait_bytes("b2b", 22, 3000);
    check_frame("b2b_f0", 0, 8'h00, 0);
    check_frame("b2b_f1", 11, 8'h01, 4);
    check("b2b_frame_gap", 32'(gc(11) - gc(10)), 32'd43);
    wait_idle("b2b", 200);
    check("b2b_end_count", 32'(fifo_count), 32'd0);

    // ---------------- overflow with stalled transmitter ----------------
    do_reset("rst_ovf");
    tx_hold = 1'b1;
    for (int i = 0; i < 17; i++) smp_log[i] = 16'(16'h0100 + 16'h0203 * i);
    push_range(0, 17);
    repeat (3) @(negedge clk);
    check("ovf_count", 32'(fifo_count), 32'd16);
    check("ovf_flag",  32'(overflow),   32'd1);
    check("ovf_busy",  32'(busy),       32'd1);
    check("ovf_bytes_held", 32'(got.size()), 32'd1);
    tx_hold = 1'b0;
    wait_bytes("ovf", 44, 6000);
    for (int f = 0; f < 4; f++)
      check_frame($sformatf("ovf_f%0d", f), 11*f, 8'(f), 4*f);
    wait_idle("ovf", 200);
    repeat (100) @(negedge clk);
    check("ovf_no_17th", 32'(got.size()), 32'd44);
    check("ovf_end_count", 32'(fifo_count), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // ---------------- 257 frames: sequence wrap ----------------
    do_reset("rst_wrap");
    tx_clks = 2;
    for (int f = 0; f < 257; f++) begin
      for (int i = 0; i < 4; i++)
        smp_log[4*f + i] = 16'(f * 977 + i * 4099 + 16'h5A3C);
      got.delete();
      got_cyc.delete();
      push_range(4*f, 4);
      wait_bytes($sformatf("wrap_f%0d", f), 11, 400);
      check_frame($sformatf("wrap_f%0d", f), 0, 8'(f), 4*f);
    end
    wait_idle("wrap", 100);
    tx_clks = 40;

    // ---------------- reset during third byte ----------------
    do_reset("rst_mid_pre");
    for (int i = 0; i < 4; i++) smp_log[i] = 16'(16'hC3A0 + i);
    push_range(0, 4);
    wait_bytes("mid", 3, 500);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("mid_rst");
    rst_n = 1'b1;
    begin
      int k = 0;
      while ((tx_active || tx_done) && k < 200) begin
        @(negedge clk);
        k++;
      end
    end
    check("mid_after_count", 32'(fifo_count), 32'd0);
    got.delete();
    got_cyc.delete();
    for (int i = 0; i < 4; i++) smp_log[i] = 16'(16'h7E81 - 16'h0111 * i);
    push_range(0, 4);
    wait_bytes("mid_new", 11, 1500);
    check_frame("mid_new", 0, 8'h00, 0);
    wait_idle("mid_new", 200);

    check("dv_never_consecutive", 32'(dv_consec), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_sample_framer.md
# uart_sample_framer

Packetizes 16-bit SDR samples into framed byte streams for the UART transmitter stage, directly upstream of it. Samples arrive on a single-cycle valid strobe and are buffered in an internal FIFO. Once a full frame's worth is held, the block emits a sync byte, a sequence byte, the samples MSB-first and an XOR checksum. It hands each byte to the transmitter with a one-cycle data-valid pulse, then waits for that byte to complete before issuing the next.

## Interface
- FRAME_LEN, 4: samples per frame, 1..FIFO_DEPTH.
- FIFO_DEPTH, 16: sample FIFO depth, power of two, ≥ FRAME_LEN.
- SYNC_BYTE, 8'hA5: first byte of every frame.
- osc_clk  in  1  system clock; all logic on rising edge.
- i_Rst_n  in  1  asynchronous, active-low reset.
- i_Sample_DV  in  1  sample valid, one cycle per sample.
- i_Sample  in  16  sample word, two's complement, sampled when i_Sample_DV=1.
- o_Tx_DV  out  1  byte valid to transmitter, exactly one cycle per byte.
- o_Tx_Byte  out  8  byte to transmitter, stable from o_Tx_DV until next byte load.
- i_Tx_Active  in  1  transmitter busy.
- i_Tx_Done  in  1  transmitter done; high ≥1 cycle after stop bit, low again once the transmitter is idle.
- o_Busy  out  1  high while a frame is in progress (any state except S_IDLE).
- o_Fifo_Count  out  $clog2(FIFO_DEPTH)+1  samples currently buffered.
- o_Overflow  out  1  sticky; set when a sample is dropped because the FIFO is full.

## Operation
- Reset values: o_Tx_DV=0, o_Tx_Byte=0, o_Busy=0, o_Fifo_Count=0, o_Overflow=0, FIFO pointers=0, seq=0, state=S_IDLE.
- FIFO push: i_Sample_DV=1 and count<FIFO_DEPTH writes the sample. If count==FIFO_DEPTH, the sample is dropped and o_Overflow is set. Fullness is judged on the pre-edge count, so a same-cycle pop does not make room. Pointers wrap modulo FIFO_DEPTH.
- Simultaneous push+pop with count<FIFO_DEPTH: count unchanged.
- Frame layout (2·FRAME_LEN+3 bytes):
  - SYNC_BYTE;
  - seq;
  - for each sample: i_Sample[15:8], then i_Sample[7:0];
  - chk = XOR of seq and all sample bytes (sync excluded).
- seq is an 8-bit counter, incremented after the checksum byte completes; it wraps 0xFF→0x00.
- Byte handshake states, per byte:
  - S_LOAD: drive o_Tx_Byte and o_Tx_DV=1 for one cycle. → S_WAIT_BUSY.
  - S_WAIT_BUSY: wait for i_Tx_Active=1. → S_WAIT_DONE.
  - S_WAIT_DONE: wait for i_Tx_Done=1. → S_WAIT_IDLE.
  - S_WAIT_IDLE: wait for i_Tx_Done=0. Then advance the byte index and go to S_LOAD, or to S_IDLE after the chk byte.
- S_IDLE: when o_Fifo_Count ≥ FRAME_LEN, go to S_LOAD with byte index 0 and chk cleared.
- Pop: the FIFO head is popped in the S_WAIT_IDLE exit cycle of each sample's LSB byte. A frame therefore consumes exactly FRAME_LEN samples. Samples pushed during a frame wait for the next frame.
- chk accumulates each seq/sample byte in its S_LOAD cycle.
- Reset mid-frame: everything returns to reset values immediately, buffered samples are lost and seq=0. Any transmitter activity still in flight is ignored.

## Timing
- Push latency: sample at edge N appears in o_Fifo_Count after edge N.
- Frame start: count reaching FRAME_LEN at edge N → state S_LOAD after edge N+1 → o_Tx_DV high during cycle N+1..N+2.
- o_Tx_DV is registered and never high in two consecutive cycles.
- Inter-byte gap: next o_Tx_DV comes one cycle after i_Tx_Done is observed low.
- Back-to-back frames: if count ≥ FRAME_LEN after the chk byte, the next sync byte's o_Tx_DV follows S_IDLE by one cycle.
- No timeout: if the transmitter never responds, the block stays in its wait state until reset.

## Test plan
- Bench uses a transmitter model at 4 clocks/bit.
  - Push 0x1234, 0xABCD, 0x0001, 0x8000 with FRAME_LEN=4.
  - Expect bytes A5 00 12 34 AB CD 00 01 80 00 C1.
  - Expect o_Fifo_Count 0 and o_Busy 0 afterwards.
- Push 3 samples → no o_Tx_DV. Push the 4th → o_Tx_DV two cycles later with byte A5.
- Push 8 samples at once → two frames, seq 00 then 01, with no extra S_IDLE dwell between them.
- Push 17 samples while the transmitter is held inactive:
  - Expect o_Fifo_Count=16 and o_Overflow=1.
  - The 17th sample is absent from all frames.
- Send 256 frames → seq wraps FF→00, checksum correct on every frame.
- Assert i_Rst_n=0 during the third byte → all outputs at reset values, FIFO empty. A new frame afterwards starts with seq=00.
